// File: rtl/temp_uart_tx.sv
// Serial report transmitter: snapshots a signed BCD temperature and monitor state on `send`
// and emits it as an 8-byte ASCII line ("-123 E\r\n") over UART 8N1, LSB first.
module temp_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       temp_value_sign,
  input  logic [3:0] temp_value_huns,
  input  logic [3:0] temp_value_tens,
  input  logic [3:0] temp_value_ones,
  input  logic [1:0] state,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // Monitor state codes, matching the STATE_* values in constants.h.
  localparam logic [1:0] STATE_NORMAL    = 2'd0;
  localparam logic [1:0] STATE_ATTENTION = 2'd1;
  localparam logic [1:0] STATE_EMERGENCY = 2'd2;

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          snap_sign_q, snap_sign_d;
  logic [3:0]    snap_huns_q, snap_huns_d;
  logic [3:0]    snap_tens_q, snap_tens_d;
  logic [3:0]    snap_ones_q, snap_ones_d;
  logic [1:0]    snap_state_q, snap_state_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    cur_byte;
  logic          bit_end;
  logic [2:0]    bit_nxt;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  function automatic logic [7:0] state_ascii(input logic [1:0] s);
    logic [7:0] c;
    case (s)
      STATE_NORMAL:    c = 8'h4E;
      STATE_ATTENTION: c = 8'h41;
      STATE_EMERGENCY: c = 8'h45;
      default:         c = 8'h3F;
    endcase
    return c;
  endfunction

  // Byte currently on the wire, built from the snapshot so inputs may change mid-frame.
  always_comb begin
    cur_byte = 8'h20;
    case (byte_q)
      3'd0:    cur_byte = snap_sign_q ? 8'h2D : 8'h20;
      3'd1:    cur_byte = digit_ascii(snap_huns_q);
      3'd2:    cur_byte = digit_ascii(snap_tens_q);
      3'd3:    cur_byte = digit_ascii(snap_ones_q);
      3'd4:    cur_byte = 8'h20;
      3'd5:    cur_byte = state_ascii(snap_state_q);
      3'd6:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_end = (cnt_q == LAST_CNT);
  assign bit_nxt = bit_q + 3'd1;

  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    snap_sign_d  = snap_sign_q;
    snap_huns_d  = snap_huns_q;
    snap_tens_d  = snap_tens_q;
    snap_ones_d  = snap_ones_q;
    snap_state_d = snap_state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (fsm_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
    end

    case (fsm_q)
      S_IDLE: begin
        if (send) begin
          snap_sign_d  = temp_value_sign;
          snap_huns_d  = temp_value_huns;
          snap_tens_d  = temp_value_tens;
          snap_ones_d  = temp_value_ones;
          snap_state_d = state;
          fsm_d        = S_START;
          cnt_d        = '0;
          bit_d        = 3'd0;
          byte_d       = 3'd0;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          fsm_d = S_DATA;
          bit_d = 3'd0;
          tx_d  = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            fsm_d = S_STOP;
            tx_d  = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
      S_STOP: begin
        // The next start bit follows the stop bit directly: no idle gap inside a frame.
        if (bit_end) begin
          if (byte_q == 3'd7) begin
            fsm_d  = S_IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            fsm_d  = S_START;
            byte_d = byte_q + 3'd1;
            tx_d   = 1'b0;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      byte_q       <= 3'd0;
      snap_sign_q  <= 1'b0;
      snap_huns_q  <= 4'd0;
      snap_tens_q  <= 4'd0;
      snap_ones_q  <= 4'd0;
      snap_state_q <= 2'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      snap_sign_q  <= snap_sign_d;
      snap_huns_q  <= snap_huns_d;
      snap_tens_q  <= snap_tens_d;
      snap_ones_q  <= snap_ones_d;
      snap_state_q <= snap_state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_temp_uart_tx.sv
// Bench for temp_uart_tx: a UART monitor decodes tx into a queue that is matched
// against expected bytes pushed when each report is requested.
module tb_temp_uart_tx;

  localparam int CPB = 4;
  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_ATTN   = 2'd1;
  localparam logic [1:0] ST_EMERG  = 2'd2;
  localparam logic [1:0] ST_UNUSED = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic       sign = 1'b0;
  logic [3:0] huns = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic [1:0] st = 2'd0;
  logic       tx, busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int framing_errs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  temp_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .send(send),
    .temp_value_sign(sign), .temp_value_huns(huns), .temp_value_tens(tens),
    .temp_value_ones(ones), .state(st),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // UART monitor: finds the start bit, samples each bit mid-way, discards partial bytes on reset.
  initial begin
    bit         mon_active;
    int         mon_cnt;
    logic [7:0] mon_byte;
    mon_active = 1'b0;
    mon_cnt = 0;
    mon_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          if (mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8) begin
            mon_byte[mon_cnt / CPB - 1] = tx;
          end else if (mon_cnt / CPB == 9) begin
            if (tx !== 1'b1) framing_errs++;
            rx_q.push_back(mon_byte);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [63:0] f);
    for (int k = 0; k < 8; k++) exp_q.push_back(f[8*k +: 8]);
  endtask

  task automatic send_pulse();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  function automatic logic model_tx(input logic [63:0] f, input int i);
    int bp = i / CPB;
    int k = bp / 10;
    int b = bp % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return f[8*k + b - 1];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", tx, busy); else pass_cnt++;
    $display("reset: tx=%b busy=%b done=%b", tx, busy, done);
  endtask

  task automatic test_basic();
    int nb, nd;
    logic [7:0] e, r;
    rx_q.delete(); exp_q.delete();
    sign = 1'b1; huns = 4'd1; tens = 4'd2; ones = 4'd3; st = ST_EMERG;
    push_frame({8'h0A, 8'h0D, 8'h45, 8'h20, 8'h33, 8'h32, 8'h31, 8'h2D});
    send_pulse();
    total_cnt++; if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL basic_latency: tx=%b busy=%b want tx=0 busy=1", tx, busy); else pass_cnt++;
    nb = 0; nd = 0;
    repeat (340) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    total_cnt++; if (nb !== 320) $display("FAIL basic_busy_len: got %0d want 320", nb); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL basic_done_count: got %0d want 1", nd); else pass_cnt++;
    total_cnt++; if (tx !== 1'b1) $display("FAIL basic_tx_idle: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (rx_q.size() !== 8) $display("FAIL basic_nbytes: got %0d want 8", rx_q.size()); else pass_cnt++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      total_cnt++; if (r !== e) $display("FAIL basic_byte: got %h want %h", r, e); else pass_cnt++;
    end
    $display("basic: busy_cycles=%0d done_pulses=%0d", nb, nd);
  endtask

  task automatic test_snapshot();
    logic [7:0] e, r;
    rx_q.delete(); exp_q.delete();
    sign = 1'b1; huns = 4'd1; tens = 4'd2; ones = 4'd3; st = ST_EMERG;
    push_frame({8'h0A, 8'h0D, 8'h45, 8'h20, 8'h33, 8'h32, 8'h31, 8'h2D});
    send_pulse();
    sign = 1'b0; huns = 4'd9; tens = 4'd9; ones = 4'd9; st = ST_NORMAL;
    repeat (340) @(negedge clk);
    total_cnt++; if (rx_q.size() !== 8) $display("FAIL snap_nbytes: got %0d want 8", rx_q.size()); else pass_cnt++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      total_cnt++; if (r !== e) $display("FAIL snap_byte: got %h want %h", r, e); else pass_cnt++;
    end
    $display("snapshot: frame complete, busy=%b", busy);
  endtask

  task automatic test_ignored();
    int nb, nd;
    logic [7:0] e, r;
    rx_q.delete(); exp_q.delete();
    sign = 1'b0; huns = 4'd4; tens = 4'd5; ones = 4'd6; st = ST_ATTN;
    push_frame({8'h0A, 8'h0D, 8'h41, 8'h20, 8'h36, 8'h35, 8'h34, 8'h20});
    send_pulse();
    nb = 0; nd = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 100) send = 1'b1;
      if (c == 101) send = 1'b0;
      if (busy === 1'b1) nb++;
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    total_cnt++; if (nb !== 320) $display("FAIL ignored_busy_len: got %0d want 320", nb); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL ignored_done_count: got %0d want 1", nd); else pass_cnt++;
    total_cnt++; if (rx_q.size() !== 8) $display("FAIL ignored_nbytes: got %0d want 8", rx_q.size()); else pass_cnt++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      total_cnt++; if (r !== e) $display("FAIL ignored_byte: got %h want %h", r, e); else pass_cnt++;
    end
    $display("ignored: busy_cycles=%0d done_pulses=%0d", nb, nd);
  endtask

  task automatic test_encoding();
    logic [7:0] e, r;
    rx_q.delete(); exp_q.delete();
    sign = 1'b0; huns = 4'hA; tens = 4'h0; ones = 4'hF; st = ST_UNUSED;
    push_frame({8'h0A, 8'h0D, 8'h3F, 8'h20, 8'h3F, 8'h30, 8'h3F, 8'h20});
    send_pulse();
    repeat (340) @(negedge clk);
    total_cnt++; if (rx_q.size() !== 8) $display("FAIL enc_nbytes: got %0d want 8", rx_q.size()); else pass_cnt++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      total_cnt++; if (r !== e) $display("FAIL enc_byte: got %h want %h", r, e); else pass_cnt++;
    end
    $display("encoding: frame complete");
  endtask

  task automatic test_reset_mid();
    int nb, nd;
    logic [7:0] e, r;
    rx_q.delete(); exp_q.delete();
    sign = 1'b1; huns = 4'd7; tens = 4'd8; ones = 4'd9; st = ST_NORMAL;
    send_pulse();
    nd = 0;
    // Byte 3 occupies cycles 120..159 of the frame; its data bits start at cycle 124.
    for (int c = 0; c < 130; c++) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    send = 1'b1;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL rst_vs_send: busy=%b tx=%b want busy=0 tx=1", busy, tx); else pass_cnt++;
    rst = 1'b0; send = 1'b0;
    nb = 0;
    repeat (100) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    total_cnt++; if (nd !== 0) $display("FAIL midrst_done: got %0d pulses want 0", nd); else pass_cnt++;
    total_cnt++; if (nb !== 0) $display("FAIL midrst_resume: busy cycles %0d want 0", nb); else pass_cnt++;
    total_cnt++; if (rx_q.size() !== 3) $display("FAIL midrst_partial: got %0d bytes want 3", rx_q.size()); else pass_cnt++;
    rx_q.delete();
    sign = 1'b0; huns = 4'd0; tens = 4'd0; ones = 4'd5; st = ST_ATTN;
    push_frame({8'h0A, 8'h0D, 8'h41, 8'h20, 8'h35, 8'h30, 8'h30, 8'h20});
    send_pulse();
    repeat (340) @(negedge clk);
    total_cnt++; if (rx_q.size() !== 8) $display("FAIL midrst_fresh_nbytes: got %0d want 8", rx_q.size()); else pass_cnt++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      total_cnt++; if (r !== e) $display("FAIL midrst_fresh_byte: got %h want %h", r, e); else pass_cnt++;
    end
    $display("reset_mid: aborted frame, fresh frame complete");
  endtask

  task automatic test_back_to_back();
    logic [63:0] f;
    int errs[4];
    int first_c[4];
    logic [2:0] first_obs[4];
    logic [2:0] first_exp[4];
    logic [2:0] obs, expv;
    logic [7:0] e, r;
    int fi, ii;
    rx_q.delete(); exp_q.delete();
    f = {8'h0A, 8'h0D, 8'h41, 8'h20, 8'h30, 8'h35, 8'h32, 8'h20};
    sign = 1'b0; huns = 4'd2; tens = 4'd5; ones = 4'd0; st = ST_ATTN;
    for (int k = 0; k < 3; k++) push_frame(f);
    for (int k = 0; k < 4; k++) begin errs[k] = 0; first_c[k] = 0; first_obs[k] = 3'b0; first_exp[k] = 3'b0; end
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    // Each period: 320 frame cycles then one idle cycle carrying the done pulse.
    for (int c = 0; c < 966; c++) begin
      if (c == 642) send = 1'b0;
      fi = c / 321;
      ii = c % 321;
      if (fi < 3) begin
        if (ii < 320) expv = {model_tx(f, ii), 1'b1, 1'b0};
        else          expv = 3'b101;
      end else begin
        fi = 3;
        expv = 3'b100;
      end
      obs = {tx, busy, done};
      if (obs !== expv) begin
        if (errs[fi] == 0) begin first_c[fi] = c; first_obs[fi] = obs; first_exp[fi] = expv; end
        errs[fi]++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (errs[k] !== 0)
        $display("FAIL b2b_wave_%0d: %0d bad cycles, first at %0d {tx,busy,done}=%b want %b", k, errs[k], first_c[k], first_obs[k], first_exp[k]);
      else pass_cnt++;
    end
    total_cnt++; if (rx_q.size() !== 24) $display("FAIL b2b_nbytes: got %0d want 24", rx_q.size()); else pass_cnt++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      total_cnt++; if (r !== e) $display("FAIL b2b_byte: got %h want %h", r, e); else pass_cnt++;
    end
    $display("back_to_back: 3 frames, wave errors %0d/%0d/%0d/%0d", errs[0], errs[1], errs[2], errs[3]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_ignored();
    test_encoding();
    test_reset_mid();
    test_back_to_back();
    total_cnt++; if (framing_errs !== 0) $display("FAIL stop_bits: %0d framing errors want 0", framing_errs); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
